// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C slave exposing MEM_DEPTH byte registers behind an
// auto-incrementing register pointer (write: ptr byte then data bytes;
// read: data from the current pointer).
// Optional feature: define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low for
// STRETCH_CYCLES clk_i cycles after every ACK slot.
module i2c_slave_mem #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h22,
  parameter int unsigned MEM_DEPTH      = 16,
  parameter int unsigned STRETCH_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Reject unsupported configurations at elaboration
  if (MEM_DEPTH < 2 || MEM_DEPTH > 256 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 ||
      STRETCH_CYCLES < 1) begin : g_param_err
    $error("i2c_slave_mem: unsupported MEM_DEPTH or STRETCH_CYCLES");
  end

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    , ST_STRETCH
`endif
  } state_e;

  // Synchronizers plus one delayed copy for edge detection
  logic scl_s1_q, scl_s2_q, scl_d_q;
  logic sda_s1_q, sda_s2_q, sda_d_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_e        state_q, state_d;
  logic [1:0]    ack_ph_q, ack_ph_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [7:0]    tx_q, tx_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          busy_q, busy_d;
  logic          sda_q, sda_d;
  logic          wr_valid_q, wr_valid_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;

  logic [7:0]    mem [MEM_DEPTH];
  logic [7:0]    rx_byte;
  logic [7:0]    mem_rd;
  logic          mem_we;
  logic          ack_end;
  state_e        ack_next;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam int unsigned SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  logic          scl_q, scl_d;
  state_e        ret_q, ret_d;
  logic [SW-1:0] str_cnt_q, str_cnt_d;
`endif

  assign scl_rise  = scl_s2_q & ~scl_d_q;
  assign scl_fall  = ~scl_s2_q & scl_d_q;
  assign start_det = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;
  assign rx_byte   = {shift_q, sda_s2_q};
  assign mem_rd    = mem[ptr_q];

  // Next-state logic: bus conditions first, then per-state bit/ACK handling.
  // ACK states walk through phases: 0 = wait for slot start (SCL fall),
  // then slot end; reads add a phase for sampling the master's ACK.
  always_comb begin
    state_d    = state_q;
    ack_ph_d   = ack_ph_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    sda_d      = sda_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    ack_end    = 1'b0;
    ack_next   = ST_IDLE;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    scl_d      = scl_q;
    ret_d      = ret_q;
    str_cnt_d  = str_cnt_q;
`endif
    if (start_det || stop_det) begin
      state_d   = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_d = '0;
      ack_ph_d  = '0;
      busy_d    = 1'b0;
      sda_d     = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_d     = 1'b1;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              ack_ph_d  = '0;
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte[AW-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                mem_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = 8'(ptr_q);
                wr_data_d  = rx_byte;
                ptr_d      = ptr_q + AW'(1);
                state_d    = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (ack_ph_q == 2'd0) begin
              sda_d    = 1'b0;
              ack_ph_d = 2'd1;
              if (state_q == ST_ADDR_ACK) busy_d = 1'b1;
            end else begin
              ack_end = 1'b1;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                sda_d    = mem_rd[7];
                tx_d     = {mem_rd[6:0], 1'b0};
                ack_next = ST_RDATA;
              end else begin
                sda_d    = 1'b1;
                ack_next = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              ack_ph_d  = '0;
              ptr_d     = ptr_q + AW'(1);
              state_d   = ST_RDATA_ACK;
            end
          end else if (scl_fall) begin
            sda_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
        ST_RDATA_ACK: begin
          if (ack_ph_q == 2'd0 && scl_fall) begin
            sda_d    = 1'b1;
            ack_ph_d = 2'd1;
          end else if (ack_ph_q == 2'd1 && scl_rise) begin
            if (sda_s2_q) state_d = ST_IDLE;
            else          ack_ph_d = 2'd2;
          end else if (ack_ph_q == 2'd2 && scl_fall) begin
            ack_end  = 1'b1;
            sda_d    = mem_rd[7];
            tx_d     = {mem_rd[6:0], 1'b0};
            ack_next = ST_RDATA;
          end
        end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        ST_STRETCH: begin
          if (str_cnt_q == '0) begin
            scl_d   = 1'b1;
            state_d = ret_q;
          end else begin
            str_cnt_d = str_cnt_q - SW'(1);
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
      if (ack_end) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        state_d   = ST_STRETCH;
        ret_d     = ack_next;
        str_cnt_d = SW'(STRETCH_CYCLES - 1);
        scl_d     = 1'b0;
`else
        state_d   = ack_next;
`endif
      end
    end
  end

  // Control, pointer, synchronizer and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_d_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_d_q    <= 1'b1;
      state_q    <= ST_IDLE;
      ack_ph_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_q      <= 1'b1;
      ret_q      <= ST_IDLE;
      str_cnt_q  <= '0;
`endif
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_d_q    <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_d_q    <= sda_s2_q;
      state_q    <= state_d;
      ack_ph_q   <= ack_ph_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      sda_q      <= sda_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_q      <= scl_d;
      ret_q      <= ret_d;
      str_cnt_q  <= str_cnt_d;
`endif
    end
  end

  // Register file: not reset so contents survive rst_i
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[ptr_q] <= rx_byte;
  end

  assign sda_o      = sda_q;
  assign busy_o     = busy_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  assign scl_o      = scl_q;
`else
  assign scl_o      = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: a bit-banged I2C master on a wired-AND
// bus, monitors for write pulses and SCL hold-low runs.
module tb_i2c_slave_mem;

  localparam int unsigned Q       = 16;  // clk cycles per quarter SCL phase
  localparam int unsigned STRETCH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_o, sda_o, busy_o, wr_valid_o;
  logic [7:0] wr_addr_o, wr_data_o;
  logic       scl_bus, sda_bus;

  assign scl_bus = m_scl & scl_o;
  assign sda_bus = m_sda & sda_o;

  i2c_slave_mem #(
    .SLAVE_ADDR     (7'h22),
    .MEM_DEPTH      (16),
    .STRETCH_CYCLES (STRETCH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .scl_i      (scl_bus),
    .sda_i      (sda_bus),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .busy_o     (busy_o),
    .wr_valid_o (wr_valid_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitors: capture write pulses and measure SCL hold-low runs
  logic [7:0]  wq_addr[$];
  logic [7:0]  wq_data[$];
  int unsigned low_run   = 0;
  int unsigned total_low = 0;

  always @(negedge clk) begin
    if (wr_valid_o === 1'b1) begin
      wq_addr.push_back(wr_addr_o);
      wq_data.push_back(wr_data_o);
    end
    if (scl_o === 1'b0) begin
      low_run++;
    end else if (low_run != 0) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      chk("stretch_len", low_run, STRETCH);
`endif
      total_low += low_run;
      low_run = 0;
    end
  end

  task automatic pop_wr(input string tag, input logic [7:0] ea, input logic [7:0] ed);
    if (wq_addr.size() == 0) begin
      chk({tag, "_present"}, 0, 1);
    end else begin
      chk({tag, "_addr"}, wq_addr.pop_front(), ea);
      chk({tag, "_data"}, wq_data.pop_front(), ed);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_high();
    int unsigned n = 0;
    m_scl = 1'b1;
    while (scl_bus !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (scl_bus !== 1'b1) chk("scl_release_timeout", scl_bus, 1);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qwait();
    scl_high();   qwait();
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qwait();
    scl_high();   qwait();
    m_sda = 1'b1; qwait();
  endtask

  task automatic tx_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; qwait();
      scl_high();   qwait();
      m_scl = 1'b0; qwait();
    end
    m_sda = 1'b1; qwait();
    scl_high();   qwait();
    ack = sda_bus;
    m_scl = 1'b0; qwait();
  endtask

  task automatic rx_bit(output logic b);
    m_sda = 1'b1; qwait();
    scl_high();   qwait();
    b = sda_bus;
    m_scl = 1'b0; qwait();
  endtask

  task automatic rx_byte(input logic mack, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      rx_bit(b);
      d = {d[6:0], b};
    end
    m_sda = ~mack; qwait();
    scl_high();    qwait();
    m_scl = 1'b0;
    repeat (2) @(negedge clk);
    m_sda = 1'b1;  qwait();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [3:0] nib;
    logic       b;

    // Reset values
    repeat (4) @(negedge clk);
    chk("rst_sda_o", sda_o, 1);
    chk("rst_scl_o", scl_o, 1);
    chk("rst_busy_o", busy_o, 0);
    chk("rst_wr_valid_o", wr_valid_o, 0);
    chk("rst_wr_addr_o", wr_addr_o, 8'h00);
    chk("rst_wr_data_o", wr_data_o, 8'h00);
    rst_n = 1'b1;
    qwait();

    // Seed mem[4]=0x5C so the post-read pointer can be observed later
    i2c_start();
    tx_byte(8'h44, ack); chk("seed_addr_ack", ack, 0);
    tx_byte(8'h04, ack); chk("seed_ptr_ack", ack, 0);
    tx_byte(8'h5C, ack); chk("seed_data_ack", ack, 0);
    i2c_stop();
    pop_wr("seed_wr", 8'h04, 8'h5C);

    // Single byte write: 0x44, ptr 0x03, data 0xA5
    i2c_start();
    tx_byte(8'h44, ack); chk("w1_addr_ack", ack, 0);
    chk("w1_busy_high", busy_o, 1);
    tx_byte(8'h03, ack); chk("w1_ptr_ack", ack, 0);
    tx_byte(8'hA5, ack); chk("w1_data_ack", ack, 0);
    pop_wr("w1_wr", 8'h03, 8'hA5);
    i2c_stop();
    qwait();
    chk("w1_busy_after_stop", busy_o, 0);

    // Set pointer, repeated START, read one byte with NACK
    i2c_start();
    tx_byte(8'h44, ack); chk("r1_addr_ack", ack, 0);
    tx_byte(8'h03, ack); chk("r1_ptr_ack", ack, 0);
    i2c_start();
    tx_byte(8'h45, ack); chk("r1_raddr_ack", ack, 0);
    rx_byte(1'b0, d);    chk("r1_data", d, 8'hA5);
    i2c_stop();
    // Pointer should now be 0x04: current-address read returns seeded byte
    i2c_start();
    tx_byte(8'h45, ack); chk("r2_raddr_ack", ack, 0);
    rx_byte(1'b0, d);    chk("r2_ptr_is_4", d, 8'h5C);
    i2c_stop();

    // Wrong address 0x23: no ACK, not busy, nothing written
    i2c_start();
    tx_byte(8'h46, ack); chk("bad_addr_nack", ack, 1);
    chk("bad_addr_busy", busy_o, 0);
    tx_byte(8'h55, ack); chk("bad_addr_byte_nack", ack, 1);
    i2c_stop();
    chk("bad_addr_no_wr", wq_addr.size(), 0);

    // Write wrap: ptr 0x0F, bytes 0x11, 0x22
    i2c_start();
    tx_byte(8'h44, ack); chk("wrap_addr_ack", ack, 0);
    tx_byte(8'h0F, ack); chk("wrap_ptr_ack", ack, 0);
    tx_byte(8'h11, ack); chk("wrap_d0_ack", ack, 0);
    tx_byte(8'h22, ack); chk("wrap_d1_ack", ack, 0);
    i2c_stop();
    chk("wrap_wr_count", wq_addr.size(), 2);
    pop_wr("wrap_wr0", 8'h0F, 8'h11);
    pop_wr("wrap_wr1", 8'h00, 8'h22);
    // Read-back across the wrap with master ACK then NACK
    i2c_start();
    tx_byte(8'h44, ack); chk("wrap_rb_addr_ack", ack, 0);
    tx_byte(8'h0F, ack); chk("wrap_rb_ptr_ack", ack, 0);
    i2c_start();
    tx_byte(8'h45, ack); chk("wrap_rb_raddr_ack", ack, 0);
    rx_byte(1'b1, d);    chk("wrap_rb_mem15", d, 8'h11);
    rx_byte(1'b0, d);    chk("wrap_rb_mem0", d, 8'h22);
    i2c_stop();

    // Reset while the slave drives bit 3 (0) of mem[0]=0x22
    i2c_start();
    tx_byte(8'h44, ack); chk("rst_mid_addr_ack", ack, 0);
    tx_byte(8'h00, ack); chk("rst_mid_ptr_ack", ack, 0);
    i2c_start();
    tx_byte(8'h45, ack); chk("rst_mid_raddr_ack", ack, 0);
    nib = '0;
    for (int i = 0; i < 4; i++) begin
      rx_bit(b);
      nib = {nib[2:0], b};
    end
    chk("rst_mid_hi_nibble", nib, 4'h2);
    chk("rst_mid_sda_driven", sda_o, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sda_released", sda_o, 1);
    chk("rst_mid_busy_cleared", busy_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    qwait();
    i2c_start();
    tx_byte(8'h44, ack); chk("post_rst_addr_ack", ack, 0);
    tx_byte(8'h00, ack); chk("post_rst_ptr_ack", ack, 0);
    i2c_start();
    tx_byte(8'h45, ack); chk("post_rst_raddr_ack", ack, 0);
    rx_byte(1'b0, d);    chk("post_rst_mem_kept", d, 8'h22);
    i2c_stop();
    qwait();

    chk("no_stray_wr", wq_addr.size(), 0);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    chk("stretch_seen", (total_low != 0) ? 1 : 0, 1);
`else
    chk("scl_o_never_low", total_low + low_run, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
